// File: rtl/bus_pkg.sv
// Shared types and constants for the asynchronous peripheral bus initiator
// and the peripheral windows it addresses.
package bus_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  // Peripheral decoder windows, matched against Addr[11:4].
  localparam logic [7:0] INT_WIN   = 8'hff;
  localparam logic [7:0] AUDIO_WIN = 8'hfe;
  localparam logic [7:0] IDENT_WIN = 8'hfd;

  function automatic logic [1:0] cs_decode(input logic cs);
    return cs ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Internal request/response handshake between a host block and bus_initiator.
interface bus_initiator_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              Req;
  logic              ReqWr;
  logic              ReqCs;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqData;
  logic              Busy;
  logic              Done;
  logic              Err;
  logic [DATA_W-1:0] RdData;

  modport master (
    output Req, ReqWr, ReqCs, ReqAddr, ReqData,
    input  Busy, Done, Err, RdData
  );

  modport slave (
    input  Req, ReqWr, ReqCs, ReqAddr, ReqData,
    output Busy, Done, Err, RdData
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bus_initiator.sv
// Host-side master for the asynchronous peripheral bus: turns a one-cycle
// request into a CsN/strobe cycle with programmable setup, strobe and hold.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 3,
  parameter int HOLD_CYC     = 1,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              ResetN,
  bus_initiator_if.slave    req_if,
  output logic [ADDR_W-1:0] Addr,
  inout  wire  [DATA_W-1:0] Data,
  output logic              RdN,
  output logic              WrN,
  output logic [1:0]        CsN,
  input  logic              Wait
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
  localparam logic [7:0] WAIT_LIM  = 8'(WAIT_TIMEOUT);

  function automatic logic [3:0] sat_dec4(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? 8'hff : v + 8'd1;
  endfunction

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [7:0]        wcnt, wcnt_nxt;
  logic              wr_q, wr_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              data_oe, oe_nxt;
  logic              busy, busy_nxt;
  logic              done, done_nxt;
  logic              err, err_nxt;
  logic              err_flag, err_flag_nxt;
  logic [DATA_W-1:0] rd_data, rd_data_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              rd_n_nxt, wr_n_nxt;
  logic [1:0]        cs_n_nxt;
  logic              wait_s;

  sync2 u_wait_sync (
    .clk   (Clk),
    .rst_n (ResetN),
    .d     (Wait),
    .q     (wait_s)
  );

  assign Data           = data_oe ? data_q : 'z;
  assign req_if.Busy    = busy;
  assign req_if.Done    = done;
  assign req_if.Err     = err;
  assign req_if.RdData  = rd_data;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    wcnt_nxt     = wcnt;
    wr_nxt       = wr_q;
    data_nxt     = data_q;
    oe_nxt       = data_oe;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    err_nxt      = err;
    err_flag_nxt = err_flag;
    rd_data_nxt  = rd_data;
    addr_nxt     = Addr;
    rd_n_nxt     = RdN;
    wr_n_nxt     = WrN;
    cs_n_nxt     = CsN;

    case (state)
      IDLE: begin
        // A request coinciding with the Done pulse is dropped, not deferred.
        if (req_if.Req && !done) begin
          addr_nxt     = req_if.ReqAddr;
          wr_nxt       = req_if.ReqWr;
          data_nxt     = req_if.ReqData;
          oe_nxt       = req_if.ReqWr;
          cs_n_nxt     = cs_decode(req_if.ReqCs);
          busy_nxt     = 1'b1;
          err_nxt      = 1'b0;
          err_flag_nxt = 1'b0;
          cnt_nxt      = SETUP_LD;
          state_nxt    = SETUP;
        end
      end

      SETUP: begin
        if (cnt == 4'd0) begin
          rd_n_nxt  = wr_q;
          wr_n_nxt  = ~wr_q;
          cnt_nxt   = STROBE_LD;
          wcnt_nxt  = 8'd0;
          state_nxt = STROBE;
        end else begin
          cnt_nxt = sat_dec4(cnt);
        end
      end

      STROBE: begin
        if (cnt != 4'd0) begin
          cnt_nxt = sat_dec4(cnt);
        end else if (wait_s && (wcnt != WAIT_LIM)) begin
          wcnt_nxt = sat_inc8(wcnt);
        end else begin
          // Read data is taken on the same edge that raises the strobe,
          // even on a timeout.
          if (wait_s) err_flag_nxt = 1'b1;
          if (!wr_q) rd_data_nxt = Data;
          rd_n_nxt = 1'b1;
          wr_n_nxt = 1'b1;
          if (HOLD_CYC == 0) begin
            cs_n_nxt  = 2'b11;
            oe_nxt    = 1'b0;
            done_nxt  = 1'b1;
            err_nxt   = wait_s;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = HOLD_LD;
            state_nxt = HOLD;
          end
        end
      end

      HOLD: begin
        if (cnt == 4'd0) begin
          cs_n_nxt  = 2'b11;
          oe_nxt    = 1'b0;
          done_nxt  = 1'b1;
          err_nxt   = err_flag;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = sat_dec4(cnt);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Every bus-facing control releases on the reset edge itself.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      wcnt     <= 8'd0;
      wr_q     <= 1'b0;
      data_oe  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_flag <= 1'b0;
      rd_data  <= '0;
      Addr     <= '0;
      RdN      <= 1'b1;
      WrN      <= 1'b1;
      CsN      <= 2'b11;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wcnt     <= wcnt_nxt;
      wr_q     <= wr_nxt;
      data_oe  <= oe_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      err_flag <= err_flag_nxt;
      rd_data  <= rd_data_nxt;
      Addr     <= addr_nxt;
      RdN      <= rd_n_nxt;
      WrN      <= wr_n_nxt;
      CsN      <= cs_n_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    data_q <= data_nxt;
  end

endmodule
